// File: rtl/scp_trace_pkg.sv
// Shared types and helpers for the execution-trace monitor.
package scp_trace_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int DROP_MAX = 255;

  // Width of one packed trace entry: {stamp, pc, inst, watch words}.
  function automatic int entry_w(input int stamp_w, input int xlen, input int num_watch);
    return stamp_w + xlen + 32 + num_watch * xlen;
  endfunction

endpackage

// File: rtl/scp_trace_fifo.sv
// Trace FIFO: extra-bit pointers, head read straight from the storage registers,
// head forced to zero when empty. A push while full succeeds only if a pop frees
// the slot on the same edge.
module scp_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // Status, accept decisions and next pointers.
  always_comb begin
    count    = wptr_q - rptr_q;
    empty    = (wptr_q == rptr_q);
    full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wptr_d   = wptr_q + (AW+1)'(do_push);
    rptr_d   = rptr_q + (AW+1)'(do_pop);
    rd_valid = !empty;
    rd_data  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  end

  // Pointer registers; reset empties the FIFO immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/scp_trace_monitor.sv
// Execution-trace capture: snapshots PC, instruction and watched words every
// clock in RUN into a FIFO, halting after CYCLE_LIMIT pushes.
// Optional macro SCP_TRACE_BREAK_EN adds a PC breakpoint (brk_en, brk_pc).
module scp_trace_monitor
  import scp_trace_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int NUM_WATCH   = 4,
  parameter int CYCLE_LIMIT = 18,
  parameter int STAMP_W     = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
`ifdef SCP_TRACE_BREAK_EN
  input  logic                                        brk_en,
  input  logic [XLEN-1:0]                             brk_pc,
`endif
  input  logic                                        start,
  input  logic [XLEN-1:0]                             pc_in,
  input  logic [31:0]                                 inst_in,
  input  logic [NUM_WATCH*XLEN-1:0]                   watch_in,
  output logic                                        rd_valid,
  input  logic                                        rd_ready,
  output logic [entry_w(STAMP_W,XLEN,NUM_WATCH)-1:0]  rd_data,
  output logic [$clog2(DEPTH):0]                      count,
  output logic                                        overflow,
  output logic [7:0]                                  drop_cnt,
  output logic                                        halt_req
);

  localparam int ENTRY_W = entry_w(STAMP_W, XLEN, NUM_WATCH);

  state_t             state_q, state_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         drop_q, drop_d;

  logic               push;
  logic               pop;
  logic               full;
  logic               limit_hit;
  logic               brk_hit;
  logic [ENTRY_W-1:0] entry;

`ifdef SCP_TRACE_BREAK_EN
  assign brk_hit = brk_en && (pc_in == brk_pc);
`else
  assign brk_hit = 1'b0;
`endif

  assign limit_hit = (CYCLE_LIMIT != 0) && (stamp_q == STAMP_W'(CYCLE_LIMIT - 1));
  assign entry     = {stamp_q, pc_in, inst_in, watch_in};
  assign pop       = rd_valid && rd_ready;

  // Run-control FSM, stamp counter and drop accounting.
  always_comb begin
    state_d = state_q;
    stamp_d = stamp_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    push    = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d = RUN;
          stamp_d = '0;
          ovf_d   = 1'b0;
          drop_d  = '0;
        end
      end
      RUN: begin
        push    = 1'b1;
        stamp_d = stamp_q + 1'b1;
        // A restart keeps running; limit and breakpoint share one exit.
        if (start)                       stamp_d = '0;
        else if (limit_hit || brk_hit)   state_d = HALTED;
      end
      default: state_d = IDLE;
    endcase
    if (push && full && !pop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'(DROP_MAX)) drop_d = drop_q + 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stamp_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      stamp_q <= stamp_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  scp_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (entry),
    .pop       (pop),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .count     (count),
    .full      (full)
  );

  assign overflow = ovf_q;
  assign drop_cnt = drop_q;
  assign halt_req = (state_q == HALTED);

endmodule

// File: tb/tb_scp_trace_monitor.sv
// Bench for scp_trace_monitor: queue-based reference model compared every
// negedge, plus directed scenarios with literal expectations.
module tb_scp_trace_monitor;

  localparam int XLEN        = 32;
  localparam int DEPTH       = 16;
  localparam int NUM_WATCH   = 4;
  localparam int CYCLE_LIMIT = 18;
  localparam int STAMP_W     = 16;
  localparam int EW          = STAMP_W + XLEN + 32 + NUM_WATCH * XLEN;
  localparam int CW          = $clog2(DEPTH) + 1;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic                        start = 1'b0;
  logic                        rd_ready = 1'b0;
  logic [XLEN-1:0]             pc_in = '0;
  logic [31:0]                 inst_in = '0;
  logic [NUM_WATCH*XLEN-1:0]   watch_in = '0;
  logic                        rd_valid;
  logic [EW-1:0]               rd_data;
  logic [CW-1:0]               count;
  logic                        overflow;
  logic [7:0]                  drop_cnt;
  logic                        halt_req;
`ifdef SCP_TRACE_BREAK_EN
  logic                        brk_en = 1'b0;
  logic [XLEN-1:0]             brk_pc = '0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scp_trace_monitor #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NUM_WATCH(NUM_WATCH),
    .CYCLE_LIMIT(CYCLE_LIMIT), .STAMP_W(STAMP_W)
  ) dut (
    .clk(clk), .rst(rst),
`ifdef SCP_TRACE_BREAK_EN
    .brk_en(brk_en), .brk_pc(brk_pc),
`endif
    .start(start), .pc_in(pc_in), .inst_in(inst_in), .watch_in(watch_in),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .halt_req(halt_req)
  );

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [EW-1:0]      mq[$];
  bit                 m_run = 0, m_halt = 0, m_ovf = 0, m_pop = 0, m_last = 0, m_brk = 0;
  int                 m_drop = 0;
  logic [STAMP_W-1:0] m_stamp = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_run = 0; m_halt = 0; m_ovf = 0; m_drop = 0; m_stamp = '0;
    end else begin
`ifdef SCP_TRACE_BREAK_EN
      m_brk = brk_en && (pc_in == brk_pc);
`else
      m_brk = 0;
`endif
      m_pop = (mq.size() > 0) && rd_ready;
      if (m_pop) void'(mq.pop_front());
      if (m_run) begin
        if (mq.size() < DEPTH) mq.push_back({m_stamp, pc_in, inst_in, watch_in});
        else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
      m_last = m_run && (((CYCLE_LIMIT > 0) && (int'(m_stamp) == CYCLE_LIMIT - 1)) || m_brk);
      if (start) begin
        if (!m_run) begin m_ovf = 0; m_drop = 0; m_halt = 0; end
        m_run = 1; m_stamp = '0;
      end else if (m_run) begin
        m_stamp = m_stamp + 1'b1;
        if (m_last) begin m_run = 0; m_halt = 1; end
      end
    end
  end

  // ---------------- per-cycle compare + pop capture ----------------
  logic [EW-1:0] popped[$];
  logic [EW-1:0] exp_head;

  always @(negedge clk) begin
    exp_head = '0;
    if (mq.size() > 0) exp_head = mq[0];
    chk("rd_valid", EW'(rd_valid), EW'(mq.size() > 0));
    chk("rd_data",  rd_data, exp_head);
    chk("count",    EW'(count), EW'(mq.size()));
    chk("overflow", EW'(overflow), EW'(m_ovf));
    chk("drop_cnt", EW'(drop_cnt), EW'(m_drop));
    chk("halt_req", EW'(halt_req), EW'(m_halt));
    if (rd_valid && rd_ready && !rst) popped.push_back(rd_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Drives one cycle of processor state per step; j indexes cycles since start.
  task automatic run_cycles(input int n, input logic [31:0] pc_base, input int dbeef_at);
    for (int j = 0; j < n; j++) begin
      pc_in    = pc_base + 32'(j * 4);
      inst_in  = 32'h0000_0013 | (32'(j) << 7);
      watch_in = {32'(j + 3), (j == dbeef_at) ? 32'hDEAD_BEEF : 32'(j + 2), 32'(j + 1), 32'(j)};
      step();
    end
  endtask

  function automatic logic [STAMP_W-1:0] f_stamp(input logic [EW-1:0] e);
    return e[EW-1 -: STAMP_W];
  endfunction
  function automatic logic [XLEN-1:0] f_pc(input logic [EW-1:0] e);
    return e[EW-STAMP_W-1 -: XLEN];
  endfunction

  logic [EW-1:0] e;

  initial begin
    // Reset state.
    #1 rst = 1'b1;
    step(); step();
    chk("rst_count",    EW'(count), EW'(0));
    chk("rst_valid",    EW'(rd_valid), EW'(0));
    chk("rst_data",     rd_data, '0);
    chk("rst_halt",     EW'(halt_req), EW'(0));
    chk("rst_overflow", EW'(overflow), EW'(0));
    chk("rst_drop",     EW'(drop_cnt), EW'(0));
    rst = 1'b0;
    step();

    // 1: reset mid-run with 5 entries held.
    rd_ready = 1'b0;
    pulse_start();
    run_cycles(5, 32'h0000_0400, -1);
    chk("t1_count5", EW'(count), EW'(5));
    rst = 1'b1;
    #1;
    chk("t1_rst_count", EW'(count), EW'(0));
    chk("t1_rst_valid", EW'(rd_valid), EW'(0));
    chk("t1_rst_halt",  EW'(halt_req), EW'(0));
    #1 rst = 1'b0;
    step(); step();
    chk("t1_idle_nopush", EW'(count), EW'(0));

    // 2 and 5: free-flowing run to the cycle limit.
    popped.delete();
    rd_ready = 1'b1;
    pulse_start();
    run_cycles(25, 32'h0000_1000, 3);
    chk("t2_num", EW'(popped.size()), EW'(18));
    for (int i = 0; i < popped.size(); i++) begin
      e = popped[i];
      chk("t2_stamp", EW'(f_stamp(e)), EW'(i));
      chk("t2_pc",    EW'(f_pc(e)), EW'(32'h1000 + 32'(4 * i)));
    end
    if (popped.size() > 3) begin
      e = popped[3];
      chk("t5_watch2", EW'(e[2*XLEN +: XLEN]), EW'(32'hDEAD_BEEF));
    end
    chk("t2_halt", EW'(halt_req), EW'(1));
    chk("t2_empty", EW'(count), EW'(0));

    // 3: consumer stalled, overflow by two.
    popped.delete();
    rd_ready = 1'b0;
    pulse_start();
    run_cycles(22, 32'h0000_2000, -1);
    chk("t3_count", EW'(count), EW'(16));
    chk("t3_ovf",   EW'(overflow), EW'(1));
    chk("t3_drop",  EW'(drop_cnt), EW'(2));
    chk("t3_halt",  EW'(halt_req), EW'(1));
    rd_ready = 1'b1;
    run_cycles(20, 32'h0, -1);
    chk("t3_num", EW'(popped.size()), EW'(16));
    for (int i = 0; i < popped.size(); i++) begin
      e = popped[i];
      chk("t3_stamp", EW'(f_stamp(e)), EW'(i));
    end

    // 4: full FIFO with simultaneous push and pop.
    popped.delete();
    rd_ready = 1'b0;
    pulse_start();
    run_cycles(16, 32'h0000_3000, -1);
    chk("t4_full", EW'(count), EW'(16));
    rd_ready = 1'b1;
    run_cycles(1, 32'h0000_3040, -1);
    chk("t4_count_hold", EW'(count), EW'(16));
    chk("t4_no_drop",    EW'(drop_cnt), EW'(0));
    chk("t4_no_ovf",     EW'(overflow), EW'(0));
    run_cycles(25, 32'h0, -1);
    chk("t4_num", EW'(popped.size()), EW'(18));
    for (int i = 0; i < popped.size(); i++) begin
      e = popped[i];
      chk("t4_stamp", EW'(f_stamp(e)), EW'(i));
    end

`ifdef SCP_TRACE_BREAK_EN
    // 6: PC breakpoint at stamp 4, then resume.
    popped.delete();
    rd_ready = 1'b1;
    brk_en = 1'b1;
    brk_pc = 32'h0000_0010;
    pulse_start();
    run_cycles(12, 32'h0, -1);
    chk("t6_num",  EW'(popped.size()), EW'(5));
    if (popped.size() > 4) begin
      e = popped[4];
      chk("t6_pc4", EW'(f_pc(e)), EW'(32'h10));
    end
    chk("t6_halt", EW'(halt_req), EW'(1));
    brk_en = 1'b0;
    popped.delete();
    pulse_start();
    run_cycles(3, 32'h0000_5000, -1);
    chk("t6_resume_num", EW'(popped.size() > 0), EW'(1));
    if (popped.size() > 0) begin
      e = popped[0];
      chk("t6_resume_stamp", EW'(f_stamp(e)), EW'(0));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
